ram_input_ctrl: RTL

Sequencing controller for the three-channel 13-bank input RAM. It runs two phases. In the load phase it accepts a raster-ordered tile stream and drives the shared write address and the one-hot bank write enables. In the read phase it sweeps the read address over all rows once per horizontal window position, and drives the per-lane bank-index (`pattern_out`) rotation so that the convolution datapath sees a sliding 3-column window. It sits between the input DMA/stream source and the input RAM block, and hands read beats to the MAC array.

---
 rtl/conv_in_pkg.sv | 31 +++
 rtl/rd_valid_pipe.sv | 41 ++++
 rtl/ram_input_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/conv_in_pkg.sv
// Shared constants, state encoding and bank-rotation helper for the
// three-channel, 13-bank input RAM path. Also used by the output unscrambler.
package conv_in_pkg;

  localparam int NUM_BANKS = 13;
  localparam int DEPTH     = 19;
  localparam int ADDR_W    = 5;
  localparam int KSIZE     = 3;
  localparam int NUM_POS   = NUM_BANKS - KSIZE + 1;
  localparam int COL_W     = 4;
  localparam int PASS_W    = 4;
  localparam int PAT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } in_ctrl_state_t;

  // (k + pass) mod NUM_BANKS; the sum never reaches 2*NUM_BANKS, so a single
  // conditional subtract is enough.
  function automatic logic [PAT_W-1:0] bank_rot(input logic [COL_W-1:0] k,
                                               input logic [PASS_W-1:0] pass);
    logic [PAT_W-1:0] sum;
    sum = PAT_W'(k) + PAT_W'(pass);
    if (sum >= PAT_W'(NUM_BANKS)) sum = sum - PAT_W'(NUM_BANKS);
    return sum;
  endfunction

endpackage

// File: rtl/rd_valid_pipe.sv
// RAM read-latency tracker: delays the issue flag and the last-row flag by
// LAT cycles and reports when no read is in flight.
//   clk, rst_n      : clock, async active-low reset
//   issue, last_row : read issued this cycle / issued row is the final row
//   rd_valid        : issue delayed LAT cycles
//   rd_last_row     : last_row delayed LAT cycles
//   empty           : no issued read still in the pipe
module rd_valid_pipe #(
  parameter int LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  input  logic last_row,
  output logic rd_valid,
  output logic rd_last_row,
  output logic empty
);

  logic [LAT-1:0] vld_pipe;
  logic [LAT-1:0] last_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[0]  <= issue;
      last_pipe[0] <= issue & last_row;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  assign rd_valid    = vld_pipe[LAT-1];
  assign rd_last_row = last_pipe[LAT-1];
  assign empty       = ~|vld_pipe;

endmodule

// File: rtl/ram_input_ctrl.sv
// Load/read sequencer for the 13-bank input RAM. LOAD writes a raster tile
// one bank per beat; READ sweeps all rows once per window position and
// rotates the per-lane bank index so lanes 0..KSIZE-1 see the active window.
//   clk, rst_n                 : clock, async active-low reset
//   start                      : begin a job (IDLE only)
//   in_valid / in_ready        : pixel beat handshake (LOAD)
//   addr_write, write_enable   : row and one-hot bank enable of the write
//   rd_ready                   : consumer allows a read issue
//   addr_read                  : row being read (registered on issue)
//   pattern_out0..12           : bank index read by each lane
//   rd_valid, rd_last_row      : RAM data valid / last row of the pass
//   pass_idx                   : current window position
//   busy, done                 : job in progress / one-cycle completion
module ram_input_ctrl
  import conv_in_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [ADDR_W-1:0]    addr_write,
  output logic [NUM_BANKS-1:0] write_enable,
  input  logic                 rd_ready,
  output logic [ADDR_W-1:0]    addr_read,
  output logic [PAT_W-1:0]     pattern_out0,
  output logic [PAT_W-1:0]     pattern_out1,
  output logic [PAT_W-1:0]     pattern_out2,
  output logic [PAT_W-1:0]     pattern_out3,
  output logic [PAT_W-1:0]     pattern_out4,
  output logic [PAT_W-1:0]     pattern_out5,
  output logic [PAT_W-1:0]     pattern_out6,
  output logic [PAT_W-1:0]     pattern_out7,
  output logic [PAT_W-1:0]     pattern_out8,
  output logic [PAT_W-1:0]     pattern_out9,
  output logic [PAT_W-1:0]     pattern_out10,
  output logic [PAT_W-1:0]     pattern_out11,
  output logic [PAT_W-1:0]     pattern_out12,
  output logic                 rd_valid,
  output logic                 rd_last_row,
  output logic [PASS_W-1:0]    pass_idx,
  output logic                 busy,
  output logic                 done
);

  in_ctrl_state_t state, state_nx;
  logic [ADDR_W-1:0] row;
  logic [COL_W-1:0]  col;
  logic [PASS_W-1:0] pass;
  logic accept, issue, row_end, col_end, pass_end, pipe_empty;
  logic [NUM_BANKS-1:0][PAT_W-1:0] pat;

  assign row_end  = (row == ADDR_W'(DEPTH - 1));
  assign col_end  = (col == COL_W'(NUM_BANKS - 1));
  assign pass_end = (pass == PASS_W'(NUM_POS - 1));

  assign accept = (state == ST_LOAD) & in_valid;
  assign issue  = (state == ST_READ) & rd_ready;

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_LOAD;
      ST_LOAD:  if (accept & col_end & row_end) state_nx = ST_READ;
      ST_READ:  if (issue & row_end & pass_end) state_nx = ST_DRAIN;
      ST_DRAIN: if (pipe_empty) begin
                  done     = 1'b1;
                  state_nx = ST_IDLE;
                end
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // row/col/pass counters. row is reused: write row in LOAD, read row in READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row       <= '0;
      col       <= '0;
      pass      <= '0;
      addr_read <= '0;
    end else begin
      if ((state == ST_IDLE) && start) begin
        row  <= '0;
        col  <= '0;
        pass <= '0;
      end
      if (accept) begin
        if (col_end) begin
          col <= '0;
          row <= row_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (issue) begin
        addr_read <= row;
        if (row_end) begin
          row <= '0;
          // Hold the final window position so pass never leaves 0..NUM_POS-1.
          if (!pass_end) pass <= pass + 1'b1;
        end else begin
          row <= row + 1'b1;
        end
      end
    end
  end

  assign in_ready     = (state == ST_LOAD);
  assign busy         = (state != ST_IDLE);
  assign addr_write   = row;
  assign write_enable = accept ? (NUM_BANKS'(1) << col) : '0;
  assign pass_idx     = pass;

  rd_valid_pipe #(.LAT(RD_LAT)) u_rd_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue       (issue),
    .last_row    (row_end),
    .rd_valid    (rd_valid),
    .rd_last_row (rd_last_row),
    .empty       (pipe_empty)
  );

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_rot
    assign pat[k] = bank_rot(COL_W'(k), pass);
  end

  assign pattern_out0  = pat[0];
  assign pattern_out1  = pat[1];
  assign pattern_out2  = pat[2];
  assign pattern_out3  = pat[3];
  assign pattern_out4  = pat[4];
  assign pattern_out5  = pat[5];
  assign pattern_out6  = pat[6];
  assign pattern_out7  = pat[7];
  assign pattern_out8  = pat[8];
  assign pattern_out9  = pat[9];
  assign pattern_out10 = pat[10];
  assign pattern_out11 = pat[11];
  assign pattern_out12 = pat[12];

endmodule
